// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory port, branch redirect and decode handshake.
// The master modport belongs to the fetch queue; the slave modport is the environment side.
interface instr_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic [31:0]                  imem_addr;
    logic [31:0]                  imem_rd;
    logic                         branch_taken;
    logic [31:0]                  branch_target;
    logic                         inst_valid;
    logic                         inst_ready;
    logic [31:0]                  inst;
    logic [31:0]                  inst_pc;
    logic [31:0]                  inst_pc_plus8;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output imem_addr, inst_valid, inst, inst_pc, inst_pc_plus8, occupancy,
        input  imem_rd, branch_taken, branch_target, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst, inst_pc, inst_pc_plus8, occupancy,
        output imem_rd, branch_taken, branch_target, inst_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, captures imem words into a small {inst, pc} FIFO,
// and presents the head entry to decode; a taken branch flushes the queue and reloads the PC.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    instr_fetch_queue_if.master  fq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [31:0]     fpc;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic            pop;
    logic            push;

    // A full queue may still accept a word when the head leaves in the same cycle.
    assign pop  = (count != '0) & fq.inst_ready;
    assign push = ~fq.branch_taken & ((count < CW'(DEPTH)) | pop);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc   <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fq.branch_taken) begin
            fpc   <= fq.branch_target & ~32'h3;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fpc  <= fpc + 32'd4;
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: the entry storage has no reset; it is written only on push and its
    // contents are never observed while the matching slot is invalid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[tail] <= '{inst: fq.imem_rd, pc: fpc};
        end
    end

    assign fq.imem_addr     = fpc;
    assign fq.inst_valid    = (count != '0);
    assign fq.inst          = mem[head].inst;
    assign fq.inst_pc       = mem[head].pc;
    assign fq.inst_pc_plus8 = mem[head].pc + 32'd8;
    assign fq.occupancy     = count;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: two instances (RESET_PC 0 and near the top of the address
// space) share stimulus; a queue-based model is compared every cycle, plus directed checks.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [31:0] RST_PC0 = 32'h0000_0000;
    localparam logic [31:0] RST_PC1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        rdy = 1'b0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    instr_fetch_queue_if #(.DEPTH(DEPTH)) fq0 ();
    instr_fetch_queue_if #(.DEPTH(DEPTH)) fq1 ();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC0)) dut0 (.clk(clk), .reset(reset), .fq(fq0));
    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC1)) dut1 (.clk(clk), .reset(reset), .fq(fq1));

    assign fq0.imem_rd       = imem_word(fq0.imem_addr);
    assign fq0.branch_taken  = br;
    assign fq0.branch_target = tgt;
    assign fq0.inst_ready    = rdy;
    assign fq1.imem_rd       = imem_word(fq1.imem_addr);
    assign fq1.branch_taken  = br;
    assign fq1.branch_target = tgt;
    assign fq1.inst_ready    = rdy;

    logic [31:0]   d_addr [2];
    logic          d_valid[2];
    logic [31:0]   d_inst [2];
    logic [31:0]   d_pc   [2];
    logic [31:0]   d_pc8  [2];
    logic [CW-1:0] d_occ  [2];
    assign d_addr[0] = fq0.imem_addr;  assign d_addr[1] = fq1.imem_addr;
    assign d_valid[0] = fq0.inst_valid; assign d_valid[1] = fq1.inst_valid;
    assign d_inst[0] = fq0.inst;       assign d_inst[1] = fq1.inst;
    assign d_pc[0]   = fq0.inst_pc;    assign d_pc[1]   = fq1.inst_pc;
    assign d_pc8[0]  = fq0.inst_pc_plus8; assign d_pc8[1] = fq1.inst_pc_plus8;
    assign d_occ[0]  = fq0.occupancy;  assign d_occ[1]  = fq1.occupancy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of {inst, pc} words and a fetch PC per instance.
    logic [63:0] mq [2][$];
    logic [31:0] mfpc [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mq[k].delete();
                mfpc[k] = (k == 0) ? RST_PC0 : RST_PC1;
            end else if (br) begin
                mq[k].delete();
                mfpc[k] = {tgt[31:2], 2'b00};
            end else begin
                bit do_pop;
                bit do_push;
                do_pop  = (mq[k].size() != 0) && rdy;
                do_push = (mq[k].size() < DEPTH) || do_pop;
                if (do_pop) void'(mq[k].pop_front());
                if (do_push) begin
                    mq[k].push_back({imem_word(mfpc[k]), mfpc[k]});
                    mfpc[k] = mfpc[k] + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("m%0d_valid", k), 32'(d_valid[k]), 32'(mq[k].size() != 0));
                check($sformatf("m%0d_occ", k), 32'(d_occ[k]), 32'(mq[k].size()));
                check($sformatf("m%0d_addr", k), d_addr[k], mfpc[k]);
                if (mq[k].size() != 0) begin
                    check($sformatf("m%0d_inst", k), d_inst[k], mq[k][0][63:32]);
                    check($sformatf("m%0d_pc", k), d_pc[k], mq[k][0][31:0]);
                    check($sformatf("m%0d_pc8", k), d_pc8[k], mq[k][0][31:0] + 32'd8);
                end
            end
        end
    end

    task automatic cycle(input logic r, input logic b, input logic [31:0] t, input logic rd);
        reset = r; br = b; tgt = t; rdy = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int fill_occ [6];
        fill_occ = '{1, 2, 3, 4, 4, 4};

        @(negedge clk);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk_en = 1'b1;
        check("rst_valid", 32'(d_valid[0]), 32'h0);
        check("rst_occ", 32'(d_occ[0]), 32'h0);
        check("rst_addr0", d_addr[0], 32'h0000_0000);
        check("rst_addr1", d_addr[1], 32'hFFFF_FFF8);

        // Fill with decode stalled.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check($sformatf("fill_occ%0d", i), 32'(d_occ[0]), 32'(fill_occ[i]));
        end
        check("fill_addr", d_addr[0], 32'h0000_0010);
        check("fill_valid", 32'(d_valid[0]), 32'h1);
        check("fill_pc", d_pc[0], 32'h0000_0000);

        // Drain in order while refilling; instance 1 crosses the 2^32 wrap.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("drain_pc%0d", i), d_pc[0], 32'(4 * i));
            check($sformatf("drain_pc8_%0d", i), d_pc8[0], 32'(4 * i + 8));
            check($sformatf("drain_occ%0d", i), 32'(d_occ[0]), 32'h4);
            check($sformatf("wrap_pc%0d", i), d_pc[1], 32'hFFFF_FFF8 + 32'(4 * i));
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
        end

        // Branch with a full queue.
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        check("br_occ", 32'(d_occ[0]), 32'h0);
        check("br_valid", 32'(d_valid[0]), 32'h0);
        check("br_addr", d_addr[0], 32'h0000_0100);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("br_valid2", 32'(d_valid[0]), 32'h1);
        check("br_pc", d_pc[0], 32'h0000_0100);
        check("br_inst", d_inst[0], 32'hE000_0100);

        // Misaligned target while the head is being popped.
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_mis_occ", 32'(d_occ[0]), 32'h3);
        cycle(1'b0, 1'b1, 32'h0000_0203, 1'b1);
        check("mis_occ", 32'(d_occ[0]), 32'h0);
        check("mis_addr", d_addr[0], 32'h0000_0200);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("mis_pc", d_pc[0], 32'h0000_0200);
        check("mis_occ2", 32'(d_occ[0]), 32'h1);

        // Reset together with a branch request.
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("pre_rst_occ", 32'(d_occ[0]), 32'h3);
        cycle(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        check("mrst_occ", 32'(d_occ[0]), 32'h0);
        check("mrst_valid", 32'(d_valid[0]), 32'h0);
        check("mrst_addr0", d_addr[0], 32'h0000_0000);
        check("mrst_addr1", d_addr[1], 32'hFFFF_FFF8);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        b;
            logic [31:0] t;
            logic        rd;
            r  = ($urandom_range(0, 99) < 2);
            b  = ($urandom_range(0, 99) < 10);
            t  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom;
            rd = ($urandom_range(0, 99) < 55);
            cycle(r, b, t, rd);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage sitting directly upstream of the instruction memory.
- Owns the fetch program counter and drives the word address into imem. Captures the instruction word imem returns in the same cycle.
- Buffers fetched {instruction, PC} pairs in a small FIFO. Presents them to decode through a valid/ready handshake.
- Handles branch redirects by flushing the queue and reloading the PC.

Parameters:
DEPTH, 4, number of queue entries (power of two, >= 2)
RESET_PC, 32'h0000_0000, fetch PC value loaded on reset

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_addr  out  32  byte address to instruction memory; equals fetch PC register
imem_rd  in  32  instruction word returned by imem for imem_addr (combinational, same cycle)
branch_taken  in  1  redirect request from execute
branch_target  in  32  redirect byte address
inst_valid  out  1  head entry valid
inst_ready  in  1  decode accepts head entry this cycle
inst  out  32  head instruction word
inst_pc  out  32  byte address of head instruction
inst_pc_plus8  out  32  inst_pc + 8 (ARM architectural PC read value)
occupancy  out  $clog2(DEPTH+1)  number of valid entries

Behaviour:
- State: fetch PC register fpc, DEPTH-entry storage of {inst, pc}, head/tail pointers, count.
- imem_addr = fpc, driven directly from the register with no combinational path from inputs.
- pop = inst_valid & inst_ready.
- push = ~branch_taken & (count < DEPTH | pop).
  - Pushing while full is allowed only in the same cycle as a pop.
- On push:
  - entry[tail] <= {imem_rd, fpc}
  - tail <= tail+1 (mod DEPTH)
  - fpc <= fpc + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000)
- On pop: head <= head+1 (mod DEPTH).
- count update: count + push - pop.
- When not pushing and not branching, fpc holds. This is the stall when full with no pop.
- Outputs:
  - inst_valid = (count != 0)
  - inst, inst_pc = entry[head]
  - inst_pc_plus8 = inst_pc + 8, wrapping modulo 2^32
  - occupancy = count
- inst/inst_pc stay stable while inst_valid=1 and inst_ready=0.
- Branch (branch_taken=1), applied the same cycle:
  - head, tail and count cleared to 0; fpc <= {branch_target[31:2], 2'b00}.
  - No push that cycle.
  - A pop occurring in the branch cycle counts as completed. The flush discards all remaining entries.
  - After the branch edge: inst_valid=0 for exactly one cycle, imem_addr = aligned target. The target instruction becomes head on the following edge.
- Reset (synchronous, highest priority over branch/push/pop):
  - fpc = RESET_PC, head = tail = count = 0.
  - Outputs after the reset edge: inst_valid=0, occupancy=0, imem_addr=RESET_PC.
  - inst/inst_pc contents are don't-care while inst_valid=0.
  - Reset asserted mid-stream discards all entries and any branch request in that cycle.
- Latency:
  - Instruction at fpc is visible on inst one edge after it is addressed, provided the queue was not full.
  - Steady-state throughput is 1 instruction/cycle with inst_ready held high.
- No X propagation: entries are written only on push. inst/inst_pc may show stale data when inst_valid=0.

Test Plan:
- Fill: reset, imem returns addr-derived words (0xE000_0000|addr), inst_ready=0 for 6 cycles -> occupancy 1,2,3,4,4,4; imem_addr stops at 0x10; inst_valid=1, inst_pc=0x0.
- Drain in order: from full state, inst_ready=1 -> inst_pc sequence 0x0,0x4,0x8,0xC,0x10,...; one per cycle with no bubble; occupancy stays 4 (push+pop); inst_pc_plus8 = inst_pc+8.
- Branch with full queue: branch_taken=1, target 0x100 -> next cycle occupancy=0, inst_valid=0, imem_addr=0x100; cycle after, inst_valid=1, inst_pc=0x100, inst=0xE000_0100.
- Misaligned target and simultaneous pop: branch to 0x203 while inst_ready=1 and inst_valid=1 -> head counted as consumed; fpc=0x200; first post-flush inst_pc=0x200.
- Wrap: RESET_PC=0xFFFF_FFF8, inst_ready=1 -> inst_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; inst_pc_plus8 for 0xFFFF_FFFC = 0x0000_0004.
- Reset mid-operation: occupancy=3 with branch_taken=1 in same cycle as reset -> next cycle occupancy=0, inst_valid=0, imem_addr=RESET_PC (branch ignored).
